// File: rtl/squared_error_monitor_pkg.sv
// Shared constants, FSM encoding and width helpers for the squared-error monitor.
package squared_error_monitor_pkg;

    localparam int NUM_OUT_DEFAULT = 34;
    localparam int DATA_W_DEFAULT  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        PUBLISH = 2'd3
    } state_e;

    // Square of a (DATA_W+1)-bit difference is exact in 2*DATA_W+2 bits.
    function automatic int sqWidth(input int dataW);
        return 2 * dataW + 2;
    endfunction

    function automatic int tagWidth(input int numOut);
        return (numOut > 1) ? $clog2(numOut) : 1;
    endfunction

endpackage

// File: rtl/squared_error_monitor_pipe.sv
// Two-stage subtract / square-and-compare datapath carrying a valid bit and output tag.
module sq_err_pipe
    import squared_error_monitor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int SQ_W   = sqWidth(DATA_W),
    parameter int TAG_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [TAG_W-1:0]         tag_i,
    input  logic signed [DATA_W-1:0] predicted_i,
    input  logic signed [DATA_W-1:0] target_i,
    input  logic [SQ_W-1:0]          threshold_i,
    output logic                     s1_valid_o,
    output logic                     s2_valid_o,
    output logic [TAG_W-1:0]         s2_tag_o,
    output logic                     s2_flag_o,
    output logic [SQ_W-1:0]          s2_sq_o
);

    logic                   s1ValidQ;
    logic [TAG_W-1:0]       s1TagQ;
    logic signed [DATA_W:0] diffQ;
    logic                   s2ValidQ;
    logic [TAG_W-1:0]       s2TagQ;
    logic                   flagQ;
    logic [SQ_W-1:0]        sqQ;

    logic signed [SQ_W-1:0] diffExt;
    logic signed [SQ_W-1:0] prod;
    logic [SQ_W-1:0]        sqD;

    assign diffExt = SQ_W'(diffQ);
    assign prod    = diffExt * diffExt;
    assign sqD     = $unsigned(prod);

    // Equality with the threshold counts as converged, hence strict greater-than.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1ValidQ <= 1'b0;
            s1TagQ   <= '0;
            diffQ    <= '0;
            s2ValidQ <= 1'b0;
            s2TagQ   <= '0;
            flagQ    <= 1'b0;
            sqQ      <= '0;
        end else begin
            s1ValidQ <= valid_i;
            s1TagQ   <= tag_i;
            diffQ    <= $signed({predicted_i[DATA_W-1], predicted_i})
                      - $signed({target_i[DATA_W-1], target_i});
            s2ValidQ <= s1ValidQ;
            s2TagQ   <= s1TagQ;
            flagQ    <= (sqD > threshold_i);
            sqQ      <= sqD;
        end
    end

    assign s1_valid_o = s1ValidQ;
    assign s2_valid_o = s2ValidQ;
    assign s2_tag_o   = s2TagQ;
    assign s2_flag_o  = flagQ;
    assign s2_sq_o    = sqQ;

endmodule

// File: rtl/squared_error_monitor.sv
// Per-epoch squared-error convergence monitor; the optional SSE accumulator is
// enabled by defining ERR_ACCUM_EN.
module squared_error_monitor
    import squared_error_monitor_pkg::*;
#(
    parameter int NUM_OUT = NUM_OUT_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int THR_W   = 2 * DATA_W + 2,
    parameter int SSE_W   = 2 * DATA_W + 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [THR_W-1:0]         threshold,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] predicted,
    input  logic signed [DATA_W-1:0] target,
    output logic [NUM_OUT-1:0]       SQUARED_ERROR,
    output logic                     err_valid,
    output logic                     busy
`ifdef ERR_ACCUM_EN
    ,
    output logic [SSE_W-1:0]         sse_total
`endif
);

    localparam int SQ_W  = sqWidth(DATA_W);
    localparam int TAG_W = tagWidth(NUM_OUT);

    state_e             stateQ;
    logic [TAG_W-1:0]   idxQ;
    logic [THR_W-1:0]   thrQ;
    logic [NUM_OUT-1:0] workFlagsQ;
    logic [NUM_OUT-1:0] sqErrQ;
    logic               errValidQ;
    logic               busyQ;
    logic               inReadyQ;

    logic               accept;
    logic               startAccept;
    logic               publishNow;
    logic               s1Valid;
    logic               s2Valid;
    logic [TAG_W-1:0]   s2Tag;
    logic               s2Flag;
    logic [SQ_W-1:0]    s2Sq;

    assign accept      = in_valid && inReadyQ;
    assign startAccept = (stateQ == IDLE) && start;
    assign publishNow  = (stateQ == DRAIN) && !s1Valid && !s2Valid;

    sq_err_pipe #(
        .DATA_W (DATA_W),
        .SQ_W   (SQ_W),
        .TAG_W  (TAG_W)
    ) uPipe (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (accept),
        .tag_i       (idxQ),
        .predicted_i (predicted),
        .target_i    (target),
        .threshold_i (thrQ),
        .s1_valid_o  (s1Valid),
        .s2_valid_o  (s2Valid),
        .s2_tag_o    (s2Tag),
        .s2_flag_o   (s2Flag),
        .s2_sq_o     (s2Sq)
    );

    // Reset publishes all ones so the controller never sees a spurious "converged".
    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ    <= IDLE;
            idxQ      <= '0;
            thrQ      <= '0;
            sqErrQ    <= '1;
            errValidQ <= 1'b0;
            busyQ     <= 1'b0;
            inReadyQ  <= 1'b0;
        end else begin
            errValidQ <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (start) begin
                        thrQ     <= threshold;
                        idxQ     <= '0;
                        busyQ    <= 1'b1;
                        inReadyQ <= 1'b1;
                        stateQ   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        idxQ <= idxQ + TAG_W'(1);
                        if (idxQ == TAG_W'(NUM_OUT - 1)) begin
                            inReadyQ <= 1'b0;
                            stateQ   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (publishNow) begin
                        sqErrQ    <= workFlagsQ;
                        errValidQ <= 1'b1;
                        busyQ     <= 1'b0;
                        stateQ    <= PUBLISH;
                    end
                end
                PUBLISH: stateQ <= IDLE;
                default: stateQ <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            workFlagsQ <= '0;
        end else if (startAccept) begin
            workFlagsQ <= '0;
        end else if (s2Valid) begin
            workFlagsQ[s2Tag] <= s2Flag;
        end
    end

`ifdef ERR_ACCUM_EN
    logic [SSE_W-1:0] sseAccQ;
    logic [SSE_W-1:0] sseTotalQ;
    logic [SSE_W:0]   sseSum;

    assign sseSum = {1'b0, sseAccQ} + (SSE_W + 1)'(s2Sq);

    // Saturating running sum; only the published copy is visible outside.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sseAccQ   <= '0;
            sseTotalQ <= '0;
        end else begin
            if (startAccept) begin
                sseAccQ <= '0;
            end else if (s2Valid) begin
                sseAccQ <= sseSum[SSE_W] ? '1 : sseSum[SSE_W-1:0];
            end
            if (publishNow) begin
                sseTotalQ <= sseAccQ;
            end
        end
    end

    assign sse_total = sseTotalQ;
`else
    logic unusedSq;
    assign unusedSq = ^s2Sq;
`endif

    assign in_ready      = inReadyQ;
    assign SQUARED_ERROR = sqErrQ;
    assign err_valid     = errValidQ;
    assign busy          = busyQ;

endmodule

// File: doc/squared_error_monitor.md
Name: squared_error_monitor

Overview:
Upstream feeder of the training controller. Once per epoch it streams NUM_OUT (predicted, target) pairs from the network output layer and forms each squared error. It compares each squared error against a threshold sampled at epoch start. It then publishes the NUM_OUT-bit not-converged flag vector SQUARED_ERROR; an all-zero vector means training is converged.

Parameters:
NUM_OUT, 34, outputs evaluated per epoch; equals the width of SQUARED_ERROR.
DATA_W, 16, signed two's-complement width of predicted/target.
THR_W, 2*DATA_W+2, unsigned threshold width; equals the squared-error width SQ_W.
SSE_W, 2*DATA_W+8, accumulator width (used only with ERR_ACCUM_EN).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; synchronous, active-low.
start  in  1  single-cycle pulse that begins an epoch evaluation.
threshold  in  THR_W  convergence threshold; sampled on an accepted start.
in_valid  in  1  a predicted/target pair is presented.
in_ready  out  1  block accepts the pair this cycle.
predicted  in  DATA_W  network output, signed.
target  in  DATA_W  expected output, signed.
SQUARED_ERROR  out  NUM_OUT  bit i = 1 when output i has sq error > threshold.
err_valid  out  1  one-cycle pulse when SQUARED_ERROR is updated.
busy  out  1  high from an accepted start until publish.
sse_total  out  SSE_W  epoch sum of squared errors (ERR_ACCUM_EN only).

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; in_ready=0, err_valid=0, busy=0.
  - SQUARED_ERROR=all ones, so the downstream controller never sees a false "done".
  - Pipeline valids, counter and working flags are cleared.
  - Reset mid-epoch aborts the epoch; nothing is published.
- FSM states: IDLE, COLLECT, DRAIN, PUBLISH.
- IDLE:
  - start=1 -> latch threshold, idx=0, working flags=0, busy=1, go to COLLECT.
  - start in any other state is ignored.
- COLLECT:
  - in_ready=1.
  - A pair is accepted when in_valid&&in_ready. It is tagged with idx, then idx increments.
  - After the accept with idx==NUM_OUT-1, in_ready drops the next cycle and the FSM goes to DRAIN.
  - in_valid low simply stalls the epoch; there is no timeout.
- Pipeline (one pair per cycle, no bubbles required):
  - S1: diff = sign-extended predicted - target, DATA_W+1 bits. This is exact, so there is no overflow.
  - S2: sq = diff*diff, unsigned SQ_W=2*DATA_W+2 bits, exact. working_flag[tag] = (sq > threshold_latched); equality counts as converged.
- DRAIN: waits until the S1 and S2 valids are both empty (2 cycles), then goes to PUBLISH.
- PUBLISH (1 cycle):
  - SQUARED_ERROR <= working flags; err_valid=1; busy=0; next state IDLE.
  - Latency: last accept at edge t -> SQUARED_ERROR/err_valid visible after edge t+3.
  - A start in the publish cycle is ignored; a start on the following cycle is accepted.
- Between epochs SQUARED_ERROR holds its last value; err_valid is low except in the publish cycle.
- Boundary values:
  - threshold=0: any nonzero error sets its flag.
  - threshold=all ones: no flags are ever set.
  - Max-magnitude inputs, e.g. predicted=-2^(DATA_W-1), target=2^(DATA_W-1)-1: diff=-(2^DATA_W-1), and the square fits in SQ_W.

Optional Feature:
Macro ERR_ACCUM_EN.
- Defined: sse_total is cleared on start and accumulates every sq in S2, saturating at 2^SSE_W-1. It updates with SQUARED_ERROR at publish and holds otherwise. Reset value is 0.
- Undefined: the sse_total port and the accumulator logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state encodings, SQ_W derivation, NUM_OUT=34 default. The controller's SQUARED_ERROR width uses the same constant.
- One natural sub-module, sq_err_pipe: the S1/S2 subtract-square-compare datapath with valid/tag passthrough. The FSM, counter and flag register stay in the top level.

Test Plan:
1. Reset: hold rst=0 for 2 cycles -> SQUARED_ERROR=34'h3_FFFF_FFFF, in_ready=0, busy=0, err_valid=0.
2. Exact match, threshold=0: start, then 34 pairs with predicted=target=100 back-to-back -> err_valid one cycle, 3 cycles after the last accept; SQUARED_ERROR=0.
3. Threshold edge, threshold=25: pair 0 diff=5 (sq=25), pair 7 diff=-6 (sq=36), all others diff=0 -> SQUARED_ERROR=34'h80 (bit 7 only).
4. Stalls and ignored start: random in_valid gaps; a second start pulsed in COLLECT -> exactly 34 accepts, one publish, flags correct.
5. Extremes, threshold=all ones and DATA_W=16: predicted=-32768, target=32767 on all 34 pairs -> no flags set; with threshold=0 -> all bits set.
6. Reset mid-epoch: rst=0 after 10 accepts -> no err_valid; SQUARED_ERROR=all ones. A new epoch then runs normally. With ERR_ACCUM_EN: 34 pairs with diff=3 -> sse_total=306.
